// File: rtl/bitcalc_sequencer_pkg.sv
// Shared constants for the nibble-serial bit-op sequencer: operation codes,
// FSM state encodings and the index-width helper.
package bitcalc_sequencer_pkg;

  typedef logic [1:0] kind_t;

  localparam kind_t KIND_PASS = 2'b00;
  localparam kind_t KIND_OR   = 2'b01;
  localparam kind_t KIND_AND  = 2'b10;
  localparam kind_t KIND_XOR  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  // The index register is at least one bit wide, even when there is a single nibble
  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/bitcalc_sequencer_if.sv
// Request/result bundle between the control FSM (master) and the sequencer (slave).
interface bitcalc_sequencer_if #(parameter int NIBBLES = 4);

  logic                 START;
  logic [1:0]           KIND;
  logic [4*NIBBLES-1:0] OPA;
  logic [4*NIBBLES-1:0] OPB;
  logic                 BUSY;
  logic                 DONE;
  logic [4*NIBBLES-1:0] RESULT;
  logic                 IS_ZERO;

  modport master (output START, KIND, OPA, OPB, input BUSY, DONE, RESULT, IS_ZERO);
  modport slave  (input START, KIND, OPA, OPB, output BUSY, DONE, RESULT, IS_ZERO);

endinterface

// File: rtl/bitcalc_sequencer_bitcalc.sv
// BITCALC: the shared 4-bit bit-op unit (pass A / OR / AND / XOR) with a nibble zero flag.
module bitcalc
  import bitcalc_sequencer_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  kind_t      kind,
  output logic [3:0] y,
  output logic       is_zero
);

  always_comb begin
    y = a;
    case (kind)
      KIND_PASS: y = a;
      KIND_OR:   y = a | b;
      KIND_AND:  y = a & b;
      KIND_XOR:  y = a ^ b;
      default:   y = a;
    endcase
  end

  assign is_zero = (y == 4'h0);

endmodule

// File: rtl/bitcalc_sequencer.sv
// Feeds a W-bit bit operation through BITCALC one nibble per cycle, LSB nibble first.
// Optional BITSEQ_PASS_SKIP_EN: KIND=00 skips iteration and finishes in one cycle.
//
// state   | meaning
// ST_IDLE | waiting for START
// ST_RUN  | BUSY, one nibble per cycle through BITCALC
// ST_FIN  | DONE pulse; RESULT/IS_ZERO just updated; START accepted again
module bitcalc_sequencer
  import bitcalc_sequencer_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                CLK,
  input  logic                RESET_N,
  bitcalc_sequencer_if.slave  bus
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = idx_width(NIBBLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NIBBLES - 1);

  logic [1:0]    state;
  logic [IW-1:0] idx;
  kind_t         kind_q;
  logic [W-1:0]  opa_q;
  logic [W-1:0]  opb_q;
  logic [W-1:0]  shadow;
  logic [W-1:0]  shadow_next;
  logic          shadow_zero;
  logic [W-1:0]  result_q;
  logic          zero_q;

  logic [3:0]    nib_a;
  logic [3:0]    nib_b;
  logic [3:0]    nib_y;
  logic          nib_zero;
  logic          running;

  assign running = (state == ST_RUN);

  // BITCALC only sees operand data while iterating
  assign nib_a = running ? opa_q[idx*4 +: 4] : 4'h0;
  assign nib_b = running ? opb_q[idx*4 +: 4] : 4'h0;

  bitcalc u_bitcalc (
    .a       (nib_a),
    .b       (nib_b),
    .kind    (kind_q),
    .y       (nib_y),
    .is_zero (nib_zero)
  );

  always_comb begin
    shadow_next = shadow;
    shadow_next[idx*4 +: 4] = nib_y;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state       <= ST_IDLE;
      idx         <= '0;
      kind_q      <= KIND_PASS;
      opa_q       <= '0;
      opb_q       <= '0;
      shadow      <= '0;
      shadow_zero <= 1'b1;
      result_q    <= '0;
      zero_q      <= 1'b1;
    end else begin
      case (state)
        ST_IDLE, ST_FIN: begin
          if (bus.START) begin
            kind_q      <= bus.KIND;
            opa_q       <= bus.OPA;
            opb_q       <= bus.OPB;
            idx         <= '0;
            shadow      <= '0;
            shadow_zero <= 1'b1;
`ifdef BITSEQ_PASS_SKIP_EN
            if (bus.KIND == KIND_PASS) begin
              state    <= ST_FIN;
              result_q <= bus.OPA;
              zero_q   <= (bus.OPA == '0);
            end else begin
              state <= ST_RUN;
            end
`else
            state <= ST_RUN;
`endif
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          shadow      <= shadow_next;
          shadow_zero <= shadow_zero & nib_zero;
          if (idx == IDX_LAST) begin
            // Publish including the nibble being written on this same edge
            state    <= ST_FIN;
            result_q <= shadow_next;
            zero_q   <= shadow_zero & nib_zero;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.BUSY    = running;
  assign bus.DONE    = (state == ST_FIN);
  assign bus.RESULT  = result_q;
  assign bus.IS_ZERO = zero_q;

endmodule

// File: tb/tb_bitcalc_sequencer.sv
// Directed scoreboard bench for bitcalc_sequencer with NIBBLES=4.
module tb_bitcalc_sequencer;

  logic CLK;
  logic RESET_N;
  int   n_cmp;
  int   n_fail;
  logic [16:0] exp_q[$];

  bitcalc_sequencer_if #(.NIBBLES(4)) bus ();

  bitcalc_sequencer #(.NIBBLES(4)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

`ifdef BITSEQ_PASS_SKIP_EN
  localparam int PASS_LAT = 1;
`else
  localparam int PASS_LAT = 5;
`endif

  function automatic logic [16:0] model(input logic [1:0] k, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    case (k)
      2'b00:   r = a;
      2'b01:   r = a | b;
      2'b10:   r = a & b;
      default: r = a ^ b;
    endcase
    return {(r == 16'h0), r};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [1:0] k, input logic [15:0] a, input logic [15:0] b);
    bus.START = 1'b1;
    bus.KIND  = k;
    bus.OPA   = a;
    bus.OPB   = b;
    exp_q.push_back(model(k, a, b));
  endtask

  task automatic scramble();
    bus.START = 1'b0;
    bus.KIND  = 2'($urandom);
    bus.OPA   = 16'($urandom);
    bus.OPB   = 16'($urandom);
  endtask

  // Drives START for one edge, then scrambles inputs; returns in cycle 1 of the op
  task automatic start_op(input logic [1:0] k, input logic [15:0] a, input logic [15:0] b);
    drive(k, a, b);
    tick();
    scramble();
  endtask

  task automatic check_done_now(input string tag);
    logic [16:0] e;
    check({tag, "_done"}, 32'(bus.DONE), 32'd1);
    check({tag, "_busy_in_done"}, 32'(bus.BUSY), 32'd0);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_result"}, 32'(bus.RESULT), 32'(e[15:0]));
      check({tag, "_is_zero"}, 32'(bus.IS_ZERO), 32'(e[16]));
    end
  endtask

  // Called in cycle 1 of an op; walks to DONE checking BUSY, stability and latency
  task automatic wait_done(input string tag, input int exp_lat);
    int c;
    logic [15:0] held;
    c = 1;
    held = bus.RESULT;
    while (bus.DONE !== 1'b1 && c < 40) begin
      check({tag, "_busy"}, 32'(bus.BUSY), 32'd1);
      check({tag, "_result_held"}, 32'(bus.RESULT), 32'(held));
      tick();
      c++;
    end
    check({tag, "_latency"}, 32'(c), 32'(exp_lat));
    check_done_now(tag);
  endtask

  initial begin
    logic [15:0] last_res;
    n_cmp   = 0;
    n_fail  = 0;
    RESET_N = 1'b0;
    scramble();

    // 1: reset
    tick();
    tick();
    check("rst_busy", 32'(bus.BUSY), 32'd0);
    check("rst_done", 32'(bus.DONE), 32'd0);
    check("rst_result", 32'(bus.RESULT), 32'h0);
    check("rst_is_zero", 32'(bus.IS_ZERO), 32'd1);
    RESET_N = 1'b1;
    tick();
    check("idle_busy", 32'(bus.BUSY), 32'd0);

    // 2: OR composes 1234
    start_op(2'b01, 16'h1200, 16'h0034);
    wait_done("or", 5);
    tick();
    check("post_done_pulse", 32'(bus.DONE), 32'd0);
    check("post_done_hold", 32'(bus.RESULT), 32'h1234);

    // 3: zero results
    start_op(2'b11, 16'hA5F0, 16'hA5F0);
    wait_done("xor_zero", 5);
    tick();
    start_op(2'b10, 16'hF0F0, 16'h0F0F);
    wait_done("and_zero", 5);
    tick();

    // 4: START ignored while running, accepted in the DONE cycle
    start_op(2'b11, 16'h1234, 16'hFFFF);
    check("ign_busy1", 32'(bus.BUSY), 32'd1);
    tick();
    bus.START = 1'b1; bus.KIND = 2'b01; bus.OPA = 16'hDEAD; bus.OPB = 16'hBEEF;
    check("ign_busy2", 32'(bus.BUSY), 32'd1);
    tick();
    bus.OPA = 16'h0BAD;
    check("ign_busy3", 32'(bus.BUSY), 32'd1);
    tick();
    check("ign_busy4", 32'(bus.BUSY), 32'd1);
    check("ign_no_done4", 32'(bus.DONE), 32'd0);
    bus.START = 1'b0;
    drive(2'b10, 16'h5A5A, 16'hFF00);
    tick();
    check_done_now("ign_first");
    tick();
    scramble();
    wait_done("b2b_second", 5);
    tick();

    // 5: reset in cycle 3 aborts without DONE
    start_op(2'b01, 16'h00FF, 16'hFF00);
    tick();
    tick();
    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;
    void'(exp_q.pop_front());
    check("abort_busy", 32'(bus.BUSY), 32'd0);
    check("abort_done", 32'(bus.DONE), 32'd0);
    check("abort_result", 32'(bus.RESULT), 32'h0);
    check("abort_is_zero", 32'(bus.IS_ZERO), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_no_done", 32'(bus.DONE), 32'd0);
    end

    // 6: pass
    start_op(2'b00, 16'h00F0, 16'h1111);
    wait_done("pass", PASS_LAT);
    tick();
    start_op(2'b00, 16'h0000, 16'hFFFF);
    wait_done("pass_zero", PASS_LAT);
    tick();

    // Mixed random ops, back-to-back where START is held in the DONE cycle
    for (int i = 0; i < 8; i++) begin
      logic [1:0]  k;
      logic [15:0] a;
      logic [15:0] b;
      k = 2'($urandom);
      a = 16'($urandom);
      b = (i == 3) ? a : 16'($urandom);
      start_op(k, a, b);
      wait_done("rand", (k == 2'b00) ? PASS_LAT : 5);
      if (i[0]) tick();
    end

    last_res = bus.RESULT;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("idle_hold", 32'(bus.RESULT), 32'(last_res));
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
